// File: rtl/tc_to_fp_seq_if.sv
// Valid/ready handshake bundle for the tc_to_fp_seq converter: sample in, float out.
// The producer/consumer side uses master; the converter uses slave.
interface tc_to_fp_seq_if #(
    parameter int W = 12,
    parameter int M = 4,
    parameter int E = 3
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_sign;
    logic [E-1:0] out_exp;
    logic [M-1:0] out_sig;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_sig
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_sig
    );
endinterface

// File: rtl/tc_to_fp_seq.sv
// Serial two's-complement to sign/exponent/significand converter (value = F * 2^exp).
// Saturating abs, one-bit-per-cycle normalisation, round half-up with exponent carry/saturation.
module tc_to_fp_seq #(
    parameter int W = 12,
    parameter int M = 4,
    parameter int E = 3
) (
    input  logic           clk,
    input  logic           rst,
    tc_to_fp_seq_if.slave  io
);
    localparam int unsigned     SHIFT_MAX = W - 1 - M;
    localparam logic [E-1:0]    ECNT_INIT = E'(SHIFT_MAX);
    localparam logic [E-1:0]    EXP_MAX   = '1;
    localparam logic [M-1:0]    SIG_MAX   = '1;
    localparam logic [M-1:0]    SIG_HALF  = M'(1) << (M - 1);
    localparam logic [W-1:0]    MAG_MAX   = {1'b0, {(W-1){1'b1}}};

    if (W < M + 2) begin : g_bad_width
        $error("tc_to_fp_seq: W must be at least M+2");
    end
    if (W - 1 - M > (2 ** E) - 1) begin : g_bad_exp
        $error("tc_to_fp_seq: exponent field too narrow for W-1-M");
    end

    typedef enum logic [2:0] {IDLE, ABS, NORM, ROUND, DONE} state_t;

    state_t       state;
    logic [W-1:0] data_q;
    logic [W-1:0] sh;
    logic [E-1:0] ecnt;
    logic         sign;

    logic         in_ready_q;
    logic         out_valid_q;
    logic         out_sign_q;
    logic [E-1:0] out_exp_q;
    logic [M-1:0] out_sig_q;

    logic [W-1:0] mag;
    logic [M-1:0] frac;
    logic         rb;
    logic [E-1:0] r_exp;
    logic [M-1:0] r_sig;

    // Most-negative input has no positive twin; clamp it so sh[W-1] stays clear.
    always_comb begin
        if (!data_q[W-1]) begin
            mag = data_q;
        end else if (data_q[W-2:0] == '0) begin
            mag = MAG_MAX;
        end else begin
            mag = ~data_q + W'(1);
        end
    end

    assign frac = sh[W-2 -: M];
    assign rb   = sh[W-2-M];

    // NOTE: both outputs get a value before any branch, so no latch is inferred.
    always_comb begin
        r_exp = ecnt;
        r_sig = frac;
        if (rb) begin
            if (frac != SIG_MAX) begin
                r_sig = frac + M'(1);
            end else if (ecnt != EXP_MAX) begin
                r_exp = ecnt + E'(1);
                r_sig = SIG_HALF;
            end else begin
                r_sig = SIG_MAX;
            end
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            data_q      <= '0;
            sh          <= '0;
            ecnt        <= '0;
            sign        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_sig_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.in_valid) begin
                        data_q     <= io.in_data;
                        in_ready_q <= 1'b0;
                        state      <= ABS;
                    end
                end
                ABS: begin
                    sign  <= data_q[W-1];
                    sh    <= mag;
                    ecnt  <= ECNT_INIT;
                    state <= NORM;
                end
                NORM: begin
                    if (sh[W-2] || ecnt == '0) begin
                        state <= ROUND;
                    end else begin
                        sh   <= sh << 1;
                        ecnt <= ecnt - E'(1);
                    end
                end
                ROUND: begin
                    out_sign_q  <= sign;
                    out_exp_q   <= r_exp;
                    out_sig_q   <= r_sig;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (io.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.out_sign  = out_sign_q;
    assign io.out_exp   = out_exp_q;
    assign io.out_sig   = out_sig_q;
endmodule
